// File: rtl/sccb_diag_pkg.sv
// Shared definitions for the SCCB link-diagnostic APB completer: register
// offsets, FSM state type, ID default and CTRL bit positions.
package sccb_diag_pkg;

  // Byte offsets of the register map
  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_SCRATCH  = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_RX_ERR   = 8'h0C;
  localparam logic [7:0] OFF_UPTIME   = 8'h10;
  localparam logic [7:0] OFF_DROP     = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;

  localparam logic [31:0] ID_DEFAULT = 32'h5343_4342;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  typedef enum logic {
    StIdle,
    StWait
  } state_e;

endpackage

// File: rtl/sccb_diag_apb_completer_sat_counter.sv
// Saturating up-counter with synchronous clear and hold.
// Ports: clk, rst_n (async active-low), inc (count enable), clr (zero, wins
// over everything), hold (freeze value), count (current value).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!hold && inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sccb_diag_apb_completer.sv
// APB completer exposing SCCB link diagnostics (ID, scratch, control, error,
// uptime and drop counters, status) with configurable wait states.
// Ports: pclk/preset_n (clock, async active-low reset); APB completer side
// psel/penable/pwrite/paddr/pwdata/pstrb in, pready/prdata/pslverr out;
// link_up level and rx_err pulse from the link, both synchronous to pclk.
module sccb_diag_apb_completer
  import sccb_diag_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic                  link_up,
  input  logic                  rx_err
);

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic [31:0]           scratch_q;
  logic                  freeze_q;
  logic                  link_q;
  logic                  pready_q, pslverr_q;
  logic [31:0]           prdata_q;

  logic                  latch, complete;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_strb;
  logic [7:0]            off;
  logic                  upper_clear;
  logic                  acc_err;
  logic [31:0]           rd_data;
  logic                  wr_ok, clear_pulse;
  logic [31:0]           rx_err_count, uptime_count, drop_count;

  // In IDLE the live bus is used so a zero-wait transfer completes on its setup edge.
  assign acc_addr  = (state_q == StIdle) ? paddr  : addr_q;
  assign acc_write = (state_q == StIdle) ? pwrite : write_q;
  assign acc_wdata = (state_q == StIdle) ? pwdata : wdata_q;
  assign acc_strb  = (state_q == StIdle) ? pstrb  : strb_q;

  assign off         = acc_addr[7:0];
  assign upper_clear = (ADDR_WIDTH > 8) ? ((acc_addr >> 8) == '0) : 1'b1;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    latch    = 1'b0;
    complete = 1'b0;
    case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            state_d = StWait;
            wait_d  = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;  // aborted transfer: no response, no commit
        end else if (penable) begin
          wait_d = wait_q - 4'd1;
          if (wait_d == 4'd0) begin
            complete = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_err = 1'b0;
    rd_data = '0;
    if ((acc_addr[1:0] != 2'b00) || !upper_clear || (off > OFF_STATUS)) begin
      acc_err = 1'b1;
    end else if (acc_write) begin
      acc_err = !((off == OFF_SCRATCH) || (off == OFF_CTRL));
    end else begin
      case (off)
        OFF_ID:      rd_data = ID_VALUE;
        OFF_SCRATCH: rd_data = scratch_q;
        OFF_CTRL:    rd_data[CTRL_FREEZE] = freeze_q;
        OFF_RX_ERR:  rd_data = rx_err_count;
        OFF_UPTIME:  rd_data = uptime_count;
        OFF_DROP:    rd_data = drop_count;
        OFF_STATUS:  rd_data[0] = link_up;
        default:     rd_data = '0;
      endcase
    end
  end

  assign wr_ok       = complete && acc_write && !acc_err;
  assign clear_pulse = wr_ok && (off == OFF_CTRL) && acc_wdata[CTRL_CLEAR];

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      scratch_q <= '0;
      freeze_q  <= 1'b0;
      link_q    <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      link_q    <= link_up;
      pready_q  <= complete;
      pslverr_q <= complete && acc_err;
      prdata_q  <= (complete && !acc_write) ? rd_data : '0;
      if (latch) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
      end
      if (wr_ok && (off == OFF_SCRATCH)) begin
        for (int i = 0; i < 4; i++) begin
          if (acc_strb[i]) scratch_q[8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
      if (wr_ok && (off == OFF_CTRL)) begin
        freeze_q <= acc_wdata[CTRL_FREEZE];
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_rx_err_cnt (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   (rx_err),
    .clr   (clear_pulse),
    .hold  (freeze_q),
    .count (rx_err_count)
  );

  // Uptime ignores FREEZE and CLEAR; losing the link zeroes it.
  sat_counter #(.WIDTH(32)) u_uptime_cnt (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   (1'b1),
    .clr   (!link_up),
    .hold  (1'b0),
    .count (uptime_count)
  );

  sat_counter #(.WIDTH(32)) u_drop_cnt (
    .clk   (pclk),
    .rst_n (preset_n),
    .inc   (link_q && !link_up),
    .clr   (clear_pulse),
    .hold  (freeze_q),
    .count (drop_count)
  );

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_sccb_diag_apb_completer.sv
// Bench for sccb_diag_apb_completer: one instance with zero wait states (index
// 0) and one with a single wait state (index 1), a reference model of the
// register map and a scoreboard checked whenever a completer raises pready.
module tb_sccb_diag_apb_completer;

  localparam int AW = 10;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic [1:0]    psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr [2];
  logic [31:0]   pwdata [2];
  logic [31:0]   prdata [2];
  logic [3:0]    pstrb [2];
  logic          link_up, rx_err;

  always #5 pclk = ~pclk;

  sccb_diag_apb_completer #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
    .link_up(link_up), .rx_err(rx_err)
  );

  sccb_diag_apb_completer #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
    .link_up(link_up), .rx_err(rx_err)
  );

  typedef struct {
    int            d;
    bit            rd;
    bit            err;
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  bit          rand_bg = 1'b0;
  bit [1:0]    commit_now = '0;

  // Reference register state
  logic [31:0] m_scratch [2];
  logic [31:0] m_rx [2];
  logic [31:0] m_drop [2];
  bit          m_freeze [2];
  logic [31:0] m_up;
  bit          m_prev_link;

  function automatic int ws(input int d);
    return d;  // instance index equals its wait-state count
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endfunction

  // Effect of one completed access on the reference state; returns the response.
  function automatic void ref_access(input int d, input bit wr, input logic [AW-1:0] a,
                                     input logic [31:0] wd, input logic [3:0] st,
                                     output exp_t e, output bit clr);
    int unsigned ai = a;
    bit bad;
    clr = 1'b0;
    bad = (a[1:0] != 2'b00) || (ai > 32'h18);
    if (wr && !(ai == 4 || ai == 8)) bad = 1'b1;
    e.d = d; e.rd = !wr; e.err = bad; e.data = '0; e.addr = a;
    if (!bad) begin
      if (wr) begin
        if (ai == 4) begin
          for (int i = 0; i < 4; i++) if (st[i]) m_scratch[d][8*i +: 8] = wd[8*i +: 8];
        end else begin
          m_freeze[d] = wd[1];
          clr = wd[0];
        end
      end else begin
        case (ai)
          0:  e.data = 32'h5343_4342;
          4:  e.data = m_scratch[d];
          8:  e.data = {30'd0, m_freeze[d], 1'b0};
          12: e.data = m_rx[d];
          16: e.data = m_up;
          20: e.data = m_drop[d];
          24: e.data = {31'd0, link_up};
          default: e.data = '0;
        endcase
      end
    end
  endfunction

  // Reference model: advances once per clock edge from the driven inputs.
  initial begin
    exp_t e;
    bit   clr, fz;
    forever begin
      @(posedge pclk or negedge preset_n);
      if (!preset_n) begin
        for (int d = 0; d < 2; d++) begin
          m_scratch[d] = '0; m_rx[d] = '0; m_drop[d] = '0; m_freeze[d] = 1'b0;
        end
        m_up = '0;
        m_prev_link = 1'b0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          fz  = m_freeze[d];
          clr = 1'b0;
          if (commit_now[d]) begin
            ref_access(d, pwrite[d], paddr[d], pwdata[d], pstrb[d], e, clr);
            sb.push_back(e);
          end
          if (clr) begin
            m_rx[d] = '0;
            m_drop[d] = '0;
          end else if (!fz) begin
            if (rx_err) m_rx[d] = sat(m_rx[d]);
            if (m_prev_link && !link_up) m_drop[d] = sat(m_drop[d]);
          end
        end
        m_up = link_up ? sat(m_up) : '0;
        m_prev_link = link_up;
      end
    end
  end

  // Monitor: every pready pops the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      for (int d = 0; d < 2; d++) begin
        if (preset_n && pready[d]) begin
          if (sb.size() == 0 || sb[0].d != d) begin
            checks++;
            failures++;
            $display("FAIL spurious_pready dut%0d: got pready=1, required no response pending", d);
          end else begin
            e = sb.pop_front();
            check($sformatf("pslverr dut%0d addr=0x%0h", d, e.addr), {31'd0, pslverr[d]},
                  {31'd0, e.err});
            if (e.rd) check($sformatf("prdata dut%0d addr=0x%0h", d, e.addr), prdata[d], e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge pclk);
    rx_err = rand_bg && ($urandom_range(0, 3) == 0);
    if (rand_bg && $urandom_range(0, 19) == 0) link_up = !link_up;
  endtask

  task automatic idle(input int n);
    step();
    psel = '0;
    penable = '0;
    repeat (n - 1) step();
  endtask

  task automatic xfer(input int d, input bit wr, input int unsigned a, input logic [31:0] wd,
                      input logic [3:0] st, input bit abort, input bit rx_on_commit);
    int k;
    bit done;
    step();
    psel = '0;
    penable = '0;
    psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = AW'(a); pwdata[d] = wd; pstrb[d] = st;
    commit_now[d] = (ws(d) == 0) && !abort;
    if (commit_now[d] && rx_on_commit) rx_err = 1'b1;
    k = 0;
    done = 1'b0;
    while (!done) begin
      step();
      k++;
      commit_now[d] = 1'b0;
      if (abort) begin
        psel[d] = 1'b0;
        done = 1'b1;
      end else begin
        penable[d] = 1'b1;
        if (pready[d]) begin
          done = 1'b1;
        end else if (k > 20) begin
          checks++;
          failures++;
          $display("FAIL pready_timeout dut%0d: got no pready in %0d cycles, required %0d",
                   d, k, ws(d) + 1);
          psel[d] = 1'b0;
          penable[d] = 1'b0;
          done = 1'b1;
        end else begin
          commit_now[d] = (k == ws(d));
          if (commit_now[d] && rx_on_commit) rx_err = 1'b1;
        end
      end
    end
    if (!abort && k <= 20) check($sformatf("pready_latency dut%0d", d), k, ws(d) + 1);
  endtask

  task automatic rd(input int d, input int unsigned a);
    xfer(d, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int d, input int unsigned a, input logic [31:0] wd,
                    input logic [3:0] st);
    xfer(d, 1'b1, a, wd, st, 1'b0, 1'b0);
  endtask

  // Completes a reset whose assertion has already happened.
  task automatic reset_hold();
    sb.delete();
    commit_now = '0;
    psel = '0;
    penable = '0;
    rx_err = 1'b0;
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_pready dut%0d", d), {31'd0, pready[d]}, 32'd0);
      check($sformatf("reset_pslverr dut%0d", d), {31'd0, pslverr[d]}, 32'd0);
      check($sformatf("reset_prdata dut%0d", d), prdata[d], 32'd0);
    end
    preset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, sel;
    int unsigned a;
    psel = '0; penable = '0; pwrite = '0; pslverr = 'x;
    for (int i = 0; i < 2; i++) begin
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
    end
    link_up = 1'b0;
    rx_err = 1'b0;
    preset_n = 1'b0;
    reset_hold();

    // One wait state: ID, strobed scratch, illegal counter write
    rd(1, 'h00);
    wr(1, 'h04, 32'hDEAD_BEEF, 4'b0101);
    rd(1, 'h04);
    wr(1, 'h0C, 32'h1234_5678, 4'hF);
    rd(1, 'h0C);

    // rx_err counting, then CLEAR colliding with a pulse
    repeat (5) begin step(); rx_err = 1'b1; step(); end
    rd(1, 'h0C);
    xfer(1, 1'b1, 'h08, 32'h1, 4'hF, 1'b0, 1'b1);
    rd(1, 'h0C);
    rd(1, 'h08);

    // FREEZE holds the count; CLEAR still zeroes it
    wr(1, 'h08, 32'hFFFF_FFFE, 4'hF);
    repeat (3) begin step(); rx_err = 1'b1; step(); end
    rd(1, 'h0C);
    rd(1, 'h08);
    wr(1, 'h08, 32'h3, 4'hF);
    rd(1, 'h0C);
    wr(1, 'h08, 32'h0, 4'hF);

    // Uptime and drop counting
    step(); link_up = 1'b1;
    idle(100);
    rd(1, 'h10);
    rd(1, 'h18);
    step(); link_up = 1'b0;
    idle(2);
    rd(1, 'h10);
    rd(1, 'h14);
    rd(0, 'h14);

    // Saturation from a preloaded count
    step();
    force dut1.u_rx_err_cnt.count_q = 32'hFFFF_FFFE;
    m_rx[1] = 32'hFFFF_FFFE;
    step();
    release dut1.u_rx_err_cnt.count_q;
    repeat (3) begin step(); rx_err = 1'b1; step(); end
    rd(1, 'h0C);

    // Unmapped and misaligned reads, aborted write
    rd(1, 'h1C);
    rd(1, 'h02);
    rd(1, 'h100);
    xfer(1, 1'b1, 'h04, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0);
    idle(2);
    rd(1, 'h04);

    // Zero wait states, back to back
    rd(0, 'h00);
    wr(0, 'h04, 32'hCAFE_0123, 4'hF);
    rd(0, 'h04);
    wr(0, 'h04, 32'h5555_AAAA, 4'b1010);
    rd(0, 'h04);
    idle(2);

    // Randomized traffic with background link noise
    rand_bg = 1'b1;
    repeat (300) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 7) a = 4 * sel;
      else if (sel == 7) a = 'h1C;
      else if (sel == 8) a = 4 * $urandom_range(0, 6) + $urandom_range(1, 3);
      else a = $urandom_range(0, 1023);
      xfer(d, $urandom_range(0, 2) == 0, a, $urandom(), 4'($urandom_range(0, 15)),
           (d == 1) && ($urandom_range(0, 15) == 0), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_bg = 1'b0;
    idle(3);
    rx_err = 1'b0;

    // Asynchronous reset during a pready cycle
    rd(0, 'h00);
    #2 preset_n = 1'b0;
    #1 check("async_reset_pready dut0", {31'd0, pready[0]}, 32'd0);
    reset_hold();

    // Asynchronous reset in the middle of a waited write
    step();
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = AW'(4); pwdata[1] = 32'hA5A5_A5A5;
    pstrb[1] = 4'hF;
    step();
    penable[1] = 1'b1;
    #2 preset_n = 1'b0;
    #1 check("async_reset_wait dut1", {31'd0, pready[1]}, 32'd0);
    reset_hold();
    rd(1, 'h04);
    rd(1, 'h0C);
    idle(3);

    check("scoreboard_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_diag_apb_completer.md
Name: sccb_diag_apb_completer

Overview:
- APB completer placed at the far end of the SCCB bridge, on the requester port of the GTY APB bridge.
- Exposes link-diagnostic registers for the 5G SCCB link, plus an ID word and a scratch word.
- The remote host reads it to check bridge integrity and link health.
- Supports configurable wait states and reports unmapped or illegal accesses with pslverr.

Parameters:
- ADDR_WIDTH, 10: width of paddr.
- WAIT_STATES, 1: number of access-phase cycles with pready low before completion (0..15).
- ID_VALUE, 32'h5343_4342: constant returned by the ID register.

Ports:
- pclk  in  1  APB clock; all logic runs in this single clock domain.
- preset_n  in  1  reset, asynchronous assert, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  32  write data.
- pstrb  in  4  write byte strobes.
- pready  out  1  transfer complete.
- prdata  out  32  read data; valid only while pready is high.
- pslverr  out  1  error response; valid only while pready is high.
- link_up  in  1  SCCB link-up level, already synchronous to pclk.
- rx_err  in  1  one-cycle pulse per receive symbol/CRC error, synchronous to pclk.

Behaviour:
- Reset values: pready=0, prdata=0, pslverr=0, SCRATCH=0, CTRL=0, all counters=0, FSM=IDLE.
- Register map (word offsets, byte address):
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x04 SCRATCH: read/write, honours pstrb per byte.
  - 0x08 CTRL: bit0 CLEAR is write-1, self-clearing, reads 0; bit1 FREEZE is read/write. Bits [31:2] read 0 and writes to them are ignored.
  - 0x0C RX_ERR_COUNT: read-only, 32-bit saturating count of rx_err pulses.
  - 0x10 UPTIME: read-only, 32-bit saturating count of cycles since link_up last rose; forced to 0 while link_up=0.
  - 0x14 DROP_COUNT: read-only, 32-bit saturating count of link_up falling edges.
  - 0x18 STATUS: read-only, bit0 = link_up, other bits 0.
- pslverr conditions: paddr[1:0]!=0; offset >0x18; any write to an ID, counter or STATUS register. Errored writes change no state. Errored reads return prdata=0.
- FSM states:
  - IDLE: psel=1 and penable=0 (setup phase) -> WAIT; latch address, direction, data and strobes; load wait_cnt=WAIT_STATES.
  - WAIT: with psel=1 and penable=1, decrement wait_cnt each cycle. When wait_cnt reaches 0, register pready=1 together with prdata/pslverr for exactly one cycle, then go to IDLE.
  - Timing: pready is seen in access-phase cycle WAIT_STATES+1. WAIT_STATES=0 gives zero-wait APB.
  - psel drops while in WAIT (protocol abort): return to IDLE, pready stays 0, no write commits.
- Write commit and read sample both happen in the pready cycle. A read returns the counter value present before that cycle's increment.
- Back-to-back transfers: a setup phase in the cycle right after the pready cycle is accepted with no gap.
- Counters saturate at 32'hFFFF_FFFF with no wrap.
- FREEZE=1 holds RX_ERR_COUNT and DROP_COUNT. UPTIME is still forced to 0 on link loss.
- CLEAR zeroes RX_ERR_COUNT and DROP_COUNT in the commit cycle. Clear wins over a simultaneous rx_err or link drop. UPTIME is unaffected.
- link_up falling edge: DROP_COUNT increments and UPTIME=0 in the same cycle.
- Asynchronous reset mid-transfer: the FSM returns to IDLE immediately and pready deasserts.

Decomposition:
- Package sccb_diag_pkg:
  - register offset localparams;
  - state enum (IDLE, WAIT);
  - ID default;
  - CTRL bit indices.
- Sub-module sat_counter: width parameter; inputs inc, clr, hold; output count. Instantiated for RX_ERR_COUNT, UPTIME and DROP_COUNT. UPTIME drives clr from !link_up.

Test Plan:
1. WAIT_STATES=1: read 0x00 -> pready low for the first access cycle, high for the second; prdata=32'h53434342, pslverr=0.
2. Write 0x04 with 32'hDEADBEEF and pstrb=4'b0101, then read 0x04 -> 32'h00AD00EF. Write 0x0C -> pslverr=1 and the count is unchanged.
3. Pulse rx_err 5 times, then read 0x0C -> 5. Write CTRL=1 in the same cycle as an rx_err pulse, then read -> 0.
4. link_up high for 100 cycles, then low: UPTIME reads 0, DROP_COUNT reads 1. Preload RX_ERR_COUNT to 32'hFFFF_FFFE via force, pulse rx_err 3 times -> reads 32'hFFFF_FFFF.
5. Read 0x1C and read 0x02 -> pslverr=1, prdata=0. Drop psel mid-WAIT on a SCRATCH write -> SCRATCH unchanged.
6. WAIT_STATES=0, back-to-back read/write/read with no idle cycles -> each pready lands in the first access cycle and data is correct. Assert preset_n mid-WAIT -> pready=0 immediately.
